// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the multiply-accumulate sequencer.
// Saturation is only built when MAC_SEQ_SAT_EN is defined.
package mac_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int LEN_W_DEF  = 4;

  // Largest accumulator value at the default width; saturating builds clamp here.
  localparam logic [ACC_W_DEF-1:0] SAT_MAX_DEF = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_pipe.sv
// Registered multiply-accumulate stage: operand regs, product-valid flag and accumulator.
// MAC_SEQ_SAT_EN selects a saturating accumulate with a sticky overflow flag.
module mac_pipe
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf,
  output logic              pv
);

  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, a_r} * {{DATA_W{1'b0}}, b_r};

`ifdef MAC_SEQ_SAT_EN
  // One extra bit catches the carry out so the clamp can be decided in one cycle.
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + (ACC_W+1)'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (abort) begin
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (pv) begin
      if (sum[ACC_W]) begin
        acc <= {ACC_W{1'b1}};
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end
`else
  logic [ACC_W-1:0] sum;
  assign sum = acc + ACC_W'(prod);
  assign ovf = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (!abort) begin
      if (clr) begin
        acc <= '0;
      end else if (pv) begin
        acc <= sum;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      pv  <= 1'b0;
    end else if (abort) begin
      pv <= 1'b0;
    end else begin
      pv <= load;
      if (load) begin
        a_r <= in_a;
        b_r <= in_b;
      end
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer: FSM, term counter and stream handshakes around mac_pipe.
// Build option MAC_SEQ_SAT_EN enables saturating accumulation and res_ovf.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output state_t            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid and payload must hold until that edge, ready may change freely.

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic             clr, load, pv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len_q <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    clr       = 1'b0;
    load      = 1'b0;
    in_ready  = (state == LOAD);
    busy      = (state != IDLE);
    res_valid = (state == DONE);
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          clr       = 1'b1;
          cnt_nxt   = '0;
          len_nxt   = cfg_len;
          state_nxt = (cfg_len != '0) ? LOAD : DONE;
        end
        LOAD: if (in_valid) begin
          load    = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt + 1'b1 == len_q) state_nxt = DRAIN;
        end
        DRAIN: if (pv) state_nxt = DONE;
        DONE:  if (res_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  mac_pipe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (load),
    .abort (abort),
    .in_a  (in_a),
    .in_b  (in_b),
    .acc   (res_data),
    .ovf   (res_ovf),
    .pv    (pv)
  );

  assign dbg_state = state;

endmodule
